// File: rtl/traffic_pkg.sv
// Shared light encodings and sequencer state codes for the crossing block.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package traffic_pkg;

    // Traffic head, one-hot: red / amber / green
    localparam logic [2:0] TL_RED   = 3'b001;
    localparam logic [2:0] TL_AMBER = 3'b010;
    localparam logic [2:0] TL_GREEN = 3'b100;

    // Pedestrian head: don't-walk, walk, dark (off half of the flash)
    localparam logic [1:0] PED_STOP = 2'b01;
    localparam logic [1:0] PED_WALK = 2'b10;
    localparam logic [1:0] PED_DARK = 2'b00;

    // Phase codes, also exported on the phase output
    typedef enum logic [2:0] {
        INIT    = 3'd0,
        GREEN   = 3'd1,
        AMBER   = 3'd2,
        ALLRED1 = 3'd3,
        WALK    = 3'd4,
        CLEAR   = 3'd5,
        ALLRED2 = 3'd6
    } state_t;

    // Larger of two durations, used to size the phase timer
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Synchronises and debounces a raw push-button into a single-cycle press pulse.
// Latency: press_vld rises DEBOUNCE+2 edges after the button is first sampled high.
// Backpressure: none; press_vld is a one-cycle pulse the consumer must capture.
module button_conditioner #(
    parameter int DEBOUNCE = 3
) (
    input  logic clk_out,
    input  logic reset,
    input  logic button,
    output logic press_vld
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE);
    localparam logic [CW-1:0] DB_ARM = CW'(DEBOUNCE - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    // Run-length of synchronised highs; saturates so a held button fires only once
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!sync2) begin
            cnt <= '0;
        end else if (cnt != DB_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pulse on the edge where the run length reaches DEBOUNCE
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            press_vld <= 1'b0;
        end else begin
            press_vld <= sync2 && (cnt == DB_ARM);
        end
    end

endmodule

// File: rtl/crossing_sequencer.sv
// Sequences traffic and pedestrian phases from a debounced request button.
// Latency: outputs registered, change on the state-entry edge (CLEAR flash toggles each edge).
// Backpressure: none; a request stays latched in req_pending until the walk phase begins.
module crossing_sequencer
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = 30,
    parameter int AMBER_T   = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 10,
    parameter int CLEAR_T   = 4,
    parameter int DEBOUNCE  = 3
) (
    input  logic       clk_out,
    input  logic       reset,
    input  logic       button,
    output logic [2:0] traff_light,
    output logic [1:0] pedes_light,
    output logic       req_pending,
    output logic [2:0] phase
);

    localparam int TMAX = max2(max2(max2(GREEN_MIN, AMBER_T), max2(ALLRED_T, WALK_T)), CLEAR_T);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    // Timer reload values: a phase of N cycles counts N-1 down to 0
    localparam logic [TW-1:0] LD_GREEN  = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] LD_AMBER  = TW'(AMBER_T - 1);
    localparam logic [TW-1:0] LD_ALLRED = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] LD_WALK   = TW'(WALK_T - 1);
    localparam logic [TW-1:0] LD_CLEAR  = TW'(CLEAR_T - 1);

    state_t        state;
    logic [TW-1:0] timer;
    logic          timer_done;
    logic          press_vld;

    button_conditioner #(
        .DEBOUNCE (DEBOUNCE)
    ) u_button (
        .clk_out   (clk_out),
        .reset     (reset),
        .button    (button),
        .press_vld (press_vld)
    );

    assign timer_done = (timer == '0);
    assign phase      = state;

    // Phase FSM with timer, registered lights and the pending-request latch
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            state       <= INIT;
            timer       <= '0;
            traff_light <= TL_RED;
            pedes_light <= PED_STOP;
            req_pending <= 1'b0;
        end else begin
            // Walk entry consumes the request and beats a same-cycle press;
            // presses during the walk itself are dropped.
            if (state == ALLRED1 && timer_done) begin
                req_pending <= 1'b0;
            end else if (press_vld && state != WALK) begin
                req_pending <= 1'b1;
            end

            // Count down; holds at 0 so GREEN can wait for a request
            if (!timer_done) begin
                timer <= timer - 1'b1;
            end

            case (state)
                INIT: begin
                    state       <= GREEN;
                    timer       <= LD_GREEN;
                    traff_light <= TL_GREEN;
                    pedes_light <= PED_STOP;
                end
                GREEN: begin
                    if (timer_done && req_pending) begin
                        state       <= AMBER;
                        timer       <= LD_AMBER;
                        traff_light <= TL_AMBER;
                    end
                end
                AMBER: begin
                    if (timer_done) begin
                        state       <= ALLRED1;
                        timer       <= LD_ALLRED;
                        traff_light <= TL_RED;
                    end
                end
                ALLRED1: begin
                    if (timer_done) begin
                        state       <= WALK;
                        timer       <= LD_WALK;
                        pedes_light <= PED_WALK;
                    end
                end
                WALK: begin
                    if (timer_done) begin
                        state       <= CLEAR;
                        timer       <= LD_CLEAR;
                        pedes_light <= PED_WALK;
                    end
                end
                CLEAR: begin
                    if (timer_done) begin
                        state       <= ALLRED2;
                        timer       <= LD_ALLRED;
                        pedes_light <= PED_STOP;
                    end else begin
                        pedes_light <= (pedes_light == PED_WALK) ? PED_DARK : PED_WALK;
                    end
                end
                ALLRED2: begin
                    if (timer_done) begin
                        state       <= GREEN;
                        timer       <= LD_GREEN;
                        traff_light <= TL_GREEN;
                    end
                end
                default: begin
                    state       <= INIT;
                    timer       <= '0;
                    traff_light <= TL_RED;
                    pedes_light <= PED_STOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crossing_sequencer.sv
// Self-checking bench for crossing_sequencer against a phase-schedule reference model.
// Latency: model predicts outputs after every clk_out edge, compared on the falling edge.
// Backpressure: n/a.
module tb_crossing_sequencer;
    import traffic_pkg::*;

    localparam int GREEN_MIN = 30;
    localparam int AMBER_T   = 3;
    localparam int ALLRED_T  = 1;
    localparam int WALK_T    = 10;
    localparam int CLEAR_T   = 4;
    localparam int DEBOUNCE  = 3;

    logic       clk_out;
    logic       reset;
    logic       button;
    logic [2:0] traff_light;
    logic [1:0] pedes_light;
    logic       req_pending;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    crossing_sequencer dut (
        .clk_out     (clk_out),
        .reset       (reset),
        .button      (button),
        .traff_light (traff_light),
        .pedes_light (pedes_light),
        .req_pending (req_pending),
        .phase       (phase)
    );

    initial clk_out = 1'b0;
    always #5 clk_out = ~clk_out;

    // ---------------- reference model ----------------
    // m_el: edges elapsed since the current phase was entered.
    // rl0..rl2: run length of consecutive high raw samples at the last three edges.
    state_t m_ph;
    int     m_el;
    bit     m_req;
    bit     m_pulse;
    int     rl0, rl1, rl2;

    function automatic int dur(input state_t p);
        case (p)
            GREEN:   return GREEN_MIN;
            AMBER:   return AMBER_T;
            ALLRED1: return ALLRED_T;
            WALK:    return WALK_T;
            CLEAR:   return CLEAR_T;
            ALLRED2: return ALLRED_T;
            default: return 1;
        endcase
    endfunction

    function automatic state_t succ(input state_t p);
        case (p)
            INIT:    return GREEN;
            GREEN:   return AMBER;
            AMBER:   return ALLRED1;
            ALLRED1: return WALK;
            WALK:    return CLEAR;
            CLEAR:   return ALLRED2;
            default: return GREEN;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = INIT; m_el = 0; m_req = 0; m_pulse = 0;
        rl0 = 0; rl1 = 0; rl2 = 0;
    endtask

    task automatic model_edge(input bit btn);
        bit leave;
        bit new_req;
        leave = (m_el + 1 >= dur(m_ph)) && (m_ph != GREEN || m_req);
        new_req = m_req;
        if (m_ph == ALLRED1 && leave) new_req = 0;
        else if (m_pulse && m_ph != WALK) new_req = 1;
        m_req = new_req;
        // A press is seen two synchroniser stages after its DEBOUNCE-th high sample
        rl2 = rl1; rl1 = rl0;
        rl0 = btn ? ((rl0 > DEBOUNCE) ? rl0 : rl0 + 1) : 0;
        m_pulse = (rl2 == DEBOUNCE);
        if (leave) begin
            m_ph = succ(m_ph); m_el = 0;
        end else begin
            m_el = m_el + 1;
        end
    endtask

    function automatic logic [2:0] exp_traff();
        if (m_ph == GREEN) return 3'b100;
        if (m_ph == AMBER) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [1:0] exp_pedes();
        if (m_ph == WALK) return 2'b10;
        if (m_ph == CLEAR) return (m_el % 2 == 0) ? 2'b10 : 2'b00;
        return 2'b01;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_traff"}, {5'd0, traff_light}, {5'd0, exp_traff()});
        chk({tag, "_pedes"}, {6'd0, pedes_light}, {6'd0, exp_pedes()});
        chk({tag, "_req"},   {7'd0, req_pending}, {7'd0, m_req});
        chk({tag, "_phase"}, {5'd0, phase},       {5'd0, m_ph});
        chk({tag, "_invariant"}, {7'd0, (pedes_light != 2'b01) && (traff_light != 3'b001)}, 8'd0);
    endtask

    task automatic step();
        @(posedge clk_out);
        if (reset) model_reset();
        else model_edge(button);
        @(negedge clk_out);
        check_all("cyc");
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic press(input int n);
        button = 1'b1;
        run(n);
        button = 1'b0;
    endtask

    task automatic run_until(input state_t p, input int limit, input string tag);
        int k;
        k = 0;
        while (m_ph != p && k < limit) begin
            step();
            k++;
        end
        chk({tag, "_reached"}, {7'd0, m_ph == p}, 8'd1);
    endtask

    // Asynchronous assert between edges, held for 'hold' edges, released on a falling edge
    task automatic do_reset(input int hold);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        run(hold);
        reset = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int glen;
        reset  = 1'b1;
        button = 1'b0;
        model_reset();
        #1;
        check_all("reset_state");
        run(2);
        reset = 1'b0;

        // Idle: GREEN holds indefinitely without a request
        run(100);
        chk("idle_phase", {5'd0, phase}, {5'd0, GREEN});
        chk("idle_req", {7'd0, req_pending}, 8'd0);

        // Full pedestrian cycle from a 5-cycle press two cycles into GREEN
        do_reset(1);
        run(3);
        press(5);
        run(60);

        // Sub-debounce pulse is ignored
        run(5);
        press(2);
        run(40);
        chk("short_press_req", {7'd0, req_pending}, 8'd0);
        chk("short_press_phase", {5'd0, phase}, {5'd0, GREEN});

        // Press long after the GREEN minimum
        do_reset(1);
        run(40);
        press(4);
        run_until(AMBER, 20, "late_press_amber");

        // WALK press discarded, CLEAR press latched, next GREEN exactly GREEN_MIN
        run_until(WALK, 40, "walk1");
        press(3);
        run(3);
        press(3);
        run_until(GREEN, 40, "green_after_clear");
        glen = 1;
        while (m_ph == GREEN && glen < 200) begin
            step();
            if (m_ph == GREEN) glen++;
        end
        chk("green_len", 8'(glen), 8'(GREEN_MIN));
        chk("after_green_phase", {5'd0, phase}, {5'd0, AMBER});

        // Reset in the middle of WALK
        run_until(GREEN, 60, "pre_walk_green");
        press(4);
        run_until(WALK, 80, "walk2");
        run(3);
        do_reset(2);
        step();
        chk("post_reset_phase", {5'd0, phase}, {5'd0, GREEN});
        chk("post_reset_req", {7'd0, req_pending}, 8'd0);

        // Randomised presses, gaps and occasional resets
        for (int i = 0; i < 60; i++) begin
            run($urandom_range(0, 40));
            press($urandom_range(1, 6));
            if ($urandom_range(0, 12) == 0) do_reset($urandom_range(1, 2));
        end
        run(80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
